instr_fetch_queue: RTL and testbench
====================================

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  DEPTH, 4, number of queue entries (power of two, 2..16)
  RESET_PC, 32'h0000_0000, fetch address after reset
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk_i  input  1  single clock, rising edge
  rst_i  input  1  asynchronous, active-low reset
  fetch_en_i  input  1  permits fetching
  redirect_i  input  1  flush queue and restart fetch
  redirect_pc_i  input  32  new fetch address
  imem_addr_o  output  32  byte address to instruction memory
  imem_instr_i  input  32  instruction word for imem_addr_o, same cycle
  instr_valid_o  output  1  head entry valid
  instr_ready_i  input  1  consumer accepts head entry
  instr_o  output  32  head instruction
  pc_o  output  32  byte address of head instruction
  count_o  output  5  occupied entries
REQ-003 Clocking and reset: one clock, clk_i; asynchronous active-low reset, rst_i.

Function
REQ-004 Queue SHALL be a FIFO of DEPTH entries, each {pc[31:0], instr[31:0]}.
REQ-005 imem_addr_o SHALL equal the fetch_pc register; no combinational path from any input to imem_addr_o.
REQ-006 Push condition: fetch_en_i=1, redirect_i=0, and (count<DEPTH or pop this cycle).
REQ-007 On push: entry {fetch_pc, imem_instr_i} written at tail; fetch_pc <= fetch_pc+4 (32-bit, wraps FFFF_FFFC -> 0000_0000).
REQ-008 Pop condition: instr_valid_o=1 and instr_ready_i=1; head advances at the clock edge.
REQ-009 instr_valid_o SHALL be 1 iff count_o!=0; instr_o/pc_o SHALL show head entry; contents don't-care when invalid.
REQ-010 Fetch-to-valid latency: 1 cycle (word pushed at edge N is visible at head after edge N when queue was empty).
REQ-011 Full with simultaneous pop: push and pop both occur; count unchanged.
REQ-012 Empty: pop impossible (valid=0); instr_ready_i ignored.
REQ-013 Pointers SHALL wrap modulo DEPTH; count_o in 0..DEPTH at all times.
REQ-014 Redirect (redirect_i=1) at edge: count <= 0, pointers reset, fetch_pc <= {redirect_pc_i[31:2],2'b00}; no push that cycle; a handshake in the same cycle counts as delivered to the consumer but has no further effect.
REQ-015 Redirect has priority over fetch_en_i, push, and pop.
REQ-016 First post-redirect instruction valid 2 cycles after redirect edge (fetch at next edge, visible after it), given fetch_en_i=1.
REQ-017 fetch_en_i=0: no push, fetch_pc held; pops continue.
REQ-018 State machine (fetch side): RUN (fetch_en_i=1, not full), STALL (full and no pop), IDLE (fetch_en_i=0); REDIRECT transitions from any state, returns to RUN/IDLE next cycle per fetch_en_i.

Reset
REQ-019 While rst_i=0: fetch_pc=RESET_PC, count_o=0, instr_valid_o=0, pointers=0, imem_addr_o=RESET_PC; instr_o/pc_o=0.
REQ-020 Reset SHALL take effect asynchronously, mid-operation included, discarding all queued entries; release is synchronous to clk_i.
REQ-021 First push SHALL occur at the first rising edge with rst_i=1 and fetch_en_i=1.

Verification
REQ-022 Reset release, fetch_en_i=1, instr_ready_i=0, memory word k = 0x1000_0000+k -> after 4 edges count_o=4, imem_addr_o=0x10, head pc_o=0x0, instr_o=0x1000_0000; stays stalled.
REQ-023 Then instr_ready_i=1 continuously -> one entry per cycle: pc_o 0x0,0x4,0x8,...; count_o holds 4; no skipped or duplicated pc.
REQ-024 Redirect_pc_i=0x0000_0043 while full -> next cycle count_o=0, valid=0, imem_addr_o=0x40; one cycle later pc_o=0x40, instr_o=0x1000_0010.
REQ-025 fetch_en_i toggled 1,0,1,0 with instr_ready_i=1 -> pcs delivered strictly sequential, count_o never exceeds 1.
REQ-026 rst_i pulsed low mid-cycle with count_o=3 -> instr_valid_o=0 and imem_addr_o=RESET_PC immediately, before next clock edge.
REQ-027 Redirect to 0xFFFF_FFF8 -> delivered pcs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: sequential PC generator feeding a DEPTH-entry FIFO
// of {pc, instr} pairs, with single-cycle flush-and-restart on redirect.
module instr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        fetch_en_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_instr_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [4:0]  count_o
);

    localparam int          PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0]  DEPTH_C = 5'(DEPTH);
    localparam logic [31:0] PC_STEP = 32'd4;
    localparam logic [31:0] PC_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STALL    = 2'd2,
        ST_REDIRECT = 2'd3
    } fetch_state_t;

    logic [31:0]   fetch_pc_r;
    logic [31:0]   pc_q_r    [DEPTH];
    logic [31:0]   instr_q_r [DEPTH];
    logic [PW-1:0] head_r;
    logic [PW-1:0] tail_r;
    logic [4:0]    count_r;
    fetch_state_t  state_r;

    logic          full_s;
    logic          valid_s;
    logic          pop_s;
    logic          push_s;
    logic [4:0]    count_next_s;
    fetch_state_t  state_next_s;

    // Handshake and occupancy decode; redirect suppresses both push and pop.
    always_comb begin
        full_s  = (count_r == DEPTH_C);
        valid_s = (count_r != 5'd0);
        pop_s   = valid_s & instr_ready_i & ~redirect_i;
        push_s  = fetch_en_i & ~redirect_i & (~full_s | pop_s);
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + 5'd1;
            2'b01:   count_next_s = count_r - 5'd1;
            default: count_next_s = count_r;
        endcase
    end

    // Fetch-side state decode: redirect wins, then enable, then back-pressure.
    always_comb begin
        state_next_s = ST_RUN;
        if (redirect_i) begin
            state_next_s = ST_REDIRECT;
        end else begin
            case (state_r)
                ST_REDIRECT: begin
                    if (fetch_en_i) begin
                        state_next_s = ST_RUN;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                default: begin
                    if (!fetch_en_i) begin
                        state_next_s = ST_IDLE;
                    end else if (full_s && !pop_s) begin
                        state_next_s = ST_STALL;
                    end else begin
                        state_next_s = ST_RUN;
                    end
                end
            endcase
        end
    end

    // Control registers: fetch PC, FIFO pointers, occupancy and fetch state.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fetch_pc_r <= RESET_PC;
            head_r     <= '0;
            tail_r     <= '0;
            count_r    <= 5'd0;
            state_r    <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
            if (redirect_i) begin
                fetch_pc_r <= redirect_pc_i & PC_MASK;
                head_r     <= '0;
                tail_r     <= '0;
                count_r    <= 5'd0;
            end else begin
                count_r <= count_next_s;
                if (push_s) begin
                    fetch_pc_r <= fetch_pc_r + PC_STEP;
                    tail_r     <= tail_r + PW'(1);
                end else begin
                    fetch_pc_r <= fetch_pc_r;
                    tail_r     <= tail_r;
                end
                if (pop_s) begin
                    head_r <= head_r + PW'(1);
                end else begin
                    head_r <= head_r;
                end
            end
        end
    end

    // Entry storage; cleared on reset so the head reads as zero while empty.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q_r[i]    <= 32'd0;
                instr_q_r[i] <= 32'd0;
            end
        end else begin
            if (push_s) begin
                pc_q_r[tail_r]    <= fetch_pc_r;
                instr_q_r[tail_r] <= imem_instr_i;
            end else begin
                pc_q_r[tail_r]    <= pc_q_r[tail_r];
                instr_q_r[tail_r] <= instr_q_r[tail_r];
            end
        end
    end

    assign imem_addr_o   = fetch_pc_r;
    assign instr_valid_o = valid_s;
    assign instr_o       = instr_q_r[head_r];
    assign pc_o          = pc_q_r[head_r];
    assign count_o       = count_r;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: memory word k at byte address 4k
// holds 0x1000_0000 + k; expected values are worked out by hand per step.
module tb_instr_fetch_queue;

    logic        clk_s;
    logic        rst_s;
    logic        fetch_en_s;
    logic        redirect_s;
    logic [31:0] redirect_pc_s;
    logic [31:0] imem_addr_s;
    logic [31:0] imem_instr_s;
    logic        instr_valid_s;
    logic        instr_ready_s;
    logic [31:0] instr_s;
    logic [31:0] pc_s;
    logic [4:0]  count_s;

    int tests_run_r;
    int tests_failed_r;

    instr_fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk_i         (clk_s),
        .rst_i         (rst_s),
        .fetch_en_i    (fetch_en_s),
        .redirect_i    (redirect_s),
        .redirect_pc_i (redirect_pc_s),
        .imem_addr_o   (imem_addr_s),
        .imem_instr_i  (imem_instr_s),
        .instr_valid_o (instr_valid_s),
        .instr_ready_i (instr_ready_s),
        .instr_o       (instr_s),
        .pc_o          (pc_s),
        .count_o       (count_s)
    );

    // Instruction memory model: word index plus a fixed tag.
    assign imem_instr_s = 32'h1000_0000 + {2'b00, imem_addr_s[31:2]};

    // Free-running clock, 10 time-unit period.
    initial begin
        clk_s = 1'b0;
        forever #5 clk_s = ~clk_s;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run_r++;
        if (got !== exp) begin
            tests_failed_r++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_s);
        #1;
    endtask

    logic        fe_vec [4];
    logic [31:0] cnt_vec [4];
    logic [31:0] addr_vec [4];

    initial begin
        tests_run_r    = 0;
        tests_failed_r = 0;
        rst_s          = 1'b0;
        fetch_en_s     = 1'b0;
        redirect_s     = 1'b0;
        redirect_pc_s  = 32'd0;
        instr_ready_s  = 1'b1;

        // Held in reset across a couple of edges.
        tick();
        tick();
        check_val("rst_count", 32'(count_s), 32'd0);
        check_val("rst_valid", 32'(instr_valid_s), 32'd0);
        check_val("rst_addr", imem_addr_s, 32'h0000_0000);
        check_val("rst_instr", instr_s, 32'd0);
        check_val("rst_pc", pc_s, 32'd0);

        // Empty queue with ready high and fetch disabled: nothing moves.
        rst_s = 1'b1;
        tick();
        check_val("empty_count", 32'(count_s), 32'd0);
        check_val("empty_addr", imem_addr_s, 32'h0000_0000);

        // Fill with no consumer: four pushes then stall.
        fetch_en_s    = 1'b1;
        instr_ready_s = 1'b0;
        tick();
        check_val("first_count", 32'(count_s), 32'd1);
        check_val("first_valid", 32'(instr_valid_s), 32'd1);
        check_val("first_pc", pc_s, 32'h0000_0000);
        tick();
        tick();
        tick();
        check_val("fill_count", 32'(count_s), 32'd4);
        check_val("fill_addr", imem_addr_s, 32'h0000_0010);
        check_val("fill_pc", pc_s, 32'h0000_0000);
        check_val("fill_instr", instr_s, 32'h1000_0000);
        tick();
        check_val("stall_count", 32'(count_s), 32'd4);
        check_val("stall_addr", imem_addr_s, 32'h0000_0010);

        // Full with continuous pop: one entry per cycle, count stays at 4.
        instr_ready_s = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            check_val($sformatf("stream_pc%0d", i), pc_s, 32'(4 * i));
            check_val($sformatf("stream_instr%0d", i), instr_s, 32'h1000_0000 + 32'(i));
            check_val($sformatf("stream_count%0d", i), 32'(count_s), 32'd4);
        end
        check_val("stream_addr", imem_addr_s, 32'h0000_0028);

        // Redirect while full to a misaligned target.
        instr_ready_s = 1'b0;
        redirect_s    = 1'b1;
        redirect_pc_s = 32'h0000_0043;
        tick();
        redirect_s = 1'b0;
        check_val("redir_count", 32'(count_s), 32'd0);
        check_val("redir_valid", 32'(instr_valid_s), 32'd0);
        check_val("redir_addr", imem_addr_s, 32'h0000_0040);
        tick();
        check_val("redir_pc", pc_s, 32'h0000_0040);
        check_val("redir_instr", instr_s, 32'h1000_0010);
        check_val("redir_count1", 32'(count_s), 32'd1);

        // Toggle fetch enable with the consumer always ready.
        instr_ready_s = 1'b1;
        fe_vec   = '{1'b0, 1'b1, 1'b0, 1'b1};
        cnt_vec  = '{32'd0, 32'd1, 32'd0, 32'd1};
        addr_vec = '{32'h44, 32'h48, 32'h48, 32'h4C};
        for (int i = 0; i < 4; i++) begin
            fetch_en_s = fe_vec[i];
            tick();
            check_val($sformatf("toggle_count%0d", i), 32'(count_s), cnt_vec[i]);
            check_val($sformatf("toggle_addr%0d", i), imem_addr_s, addr_vec[i]);
            if (i % 2 == 1) begin
                check_val($sformatf("toggle_pc%0d", i), pc_s, addr_vec[i] - 32'd4);
            end
        end

        // Redirect near the top of the address space; PC wraps to zero.
        fetch_en_s    = 1'b1;
        redirect_s    = 1'b1;
        redirect_pc_s = 32'hFFFF_FFF8;
        tick();
        redirect_s = 1'b0;
        check_val("wrap_addr", imem_addr_s, 32'hFFFF_FFF8);
        tick();
        check_val("wrap_pc0", pc_s, 32'hFFFF_FFF8);
        check_val("wrap_instr0", instr_s, 32'h4FFF_FFFE);
        tick();
        check_val("wrap_pc1", pc_s, 32'hFFFF_FFFC);
        tick();
        check_val("wrap_pc2", pc_s, 32'h0000_0000);
        check_val("wrap_instr2", instr_s, 32'h1000_0000);
        check_val("wrap_addr2", imem_addr_s, 32'h0000_0004);

        // Build up three entries, then assert reset between edges.
        instr_ready_s = 1'b0;
        tick();
        tick();
        check_val("pre_rst_count", 32'(count_s), 32'd3);
        #2;
        rst_s = 1'b0;
        #1;
        check_val("async_valid", 32'(instr_valid_s), 32'd0);
        check_val("async_addr", imem_addr_s, 32'h0000_0000);
        check_val("async_count", 32'(count_s), 32'd0);
        check_val("async_pc", pc_s, 32'd0);
        #2;
        rst_s = 1'b1;
        tick();
        check_val("post_rst_count", 32'(count_s), 32'd1);
        check_val("post_rst_pc", pc_s, 32'h0000_0000);
        check_val("post_rst_addr", imem_addr_s, 32'h0000_0004);

        $display("[TB] %0d tests run, %0d failed", tests_run_r, tests_failed_r);
        $finish;
    end

endmodule
